// File: rtl/farm_sensor_qualifier.sv
// farm_sensor_qualifier
//   Conditions the farm-road loop detector before it reaches the traffic_light
//   controller. The raw detector is synchronised, debounced, latched as a
//   request that is held until the farm road has been served, and counted as
//   vehicle arrivals with a saturating counter.
//
// Ports
//   clk_i         system clock, rising edge
//   rst_i         synchronous active-high reset, overrides every other input
//   sensor_raw_i  asynchronous loop-detector output, 1 = vehicle present
//   farm_green_i  1 while traffic_light drives the farm light GREEN
//   count_clr_i   synchronous clear of the arrival counter
//   sensor_o      qualified vehicle request, drives traffic_light.sensor
//   veh_count_o   debounced arrival count, saturating at all ones
//   veh_sat_o     1 when veh_count_o is all ones
module farm_sensor_qualifier #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int GAP_CYCLES      = 50,
    parameter int CNT_W           = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             sensor_raw_i,
    input  logic             farm_green_i,
    input  logic             count_clr_i,
    output logic             sensor_o,
    output logic [CNT_W-1:0] veh_count_o,
    output logic             veh_sat_o
);

    localparam int STAB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int GAP_W  = $clog2(GAP_CYCLES + 1);

    // A counter "reaches" its limit on the edge where it would step to it,
    // so the comparison is against limit-1 on the current value.
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        REQ   = 2'b01,
        SERVE = 2'b10
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic              sync1_q;
    logic              s2_q;
    logic              deb_q, deb_d;
    logic              deb_dly_q;
    logic [STAB_W-1:0] stab_q, stab_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    state_t            state_q, state_d;
    logic              sensor_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              arrival;

    // Debounce: deb follows s2 only after s2 has disagreed with it on
    // DEBOUNCE_CYCLES consecutive edges; any agreement restarts the count.
    always_comb begin
        deb_d  = deb_q;
        stab_d = '0;
        if (s2_q != deb_q) begin
            if (stab_q == STAB_LAST) begin
                deb_d = s2_q;
            end else begin
                stab_d = stab_q + STAB_W'(1);
            end
        end
    end

    // Arrival is registered one edge after the debounced rise.
    assign arrival = deb_q & ~deb_dly_q;

    always_comb begin
        cnt_d = cnt_q;
        if (count_clr_i) begin
            cnt_d = '0;
        end else if (arrival) begin
            cnt_d = sat_inc(cnt_q);
        end
    end

    // Request FSM. Once a vehicle is seen the request is held through REQ
    // regardless of deb; only service (gap expiry or green ending with no
    // vehicle) returns to IDLE. The gap counter is zero outside SERVE so it
    // is already clear on every SERVE entry.
    always_comb begin
        state_d = IDLE;
        gap_d   = '0;
        case (state_q)
            IDLE: begin
                state_d = deb_q ? REQ : IDLE;
            end
            REQ: begin
                state_d = farm_green_i ? SERVE : REQ;
            end
            SERVE: begin
                if (!farm_green_i) begin
                    state_d = deb_q ? REQ : IDLE;
                end else if (deb_q) begin
                    state_d = SERVE;
                end else if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    state_d = SERVE;
                    gap_d   = gap_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q   <= 1'b0;
            s2_q      <= 1'b0;
            deb_q     <= 1'b0;
            deb_dly_q <= 1'b0;
            stab_q    <= '0;
            gap_q     <= '0;
            state_q   <= IDLE;
            sensor_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            sync1_q   <= sensor_raw_i;
            s2_q      <= sync1_q;
            deb_q     <= deb_d;
            deb_dly_q <= deb_q;
            stab_q    <= stab_d;
            gap_q     <= gap_d;
            state_q   <= state_d;
            // Decoded from the next state so the request appears on the
            // same edge the FSM leaves IDLE.
            sensor_q  <= (state_d != IDLE);
            cnt_q     <= cnt_d;
        end
    end

    assign sensor_o    = sensor_q;
    assign veh_count_o = cnt_q;
    assign veh_sat_o   = &cnt_q;

endmodule

// File: tb/tb_farm_sensor_qualifier.sv
// Bench for farm_sensor_qualifier with DEBOUNCE_CYCLES=4, GAP_CYCLES=8, CNT_W=8.
module tb_farm_sensor_qualifier;

    localparam int D    = 4;
    localparam int G    = 8;
    localparam int CW   = 8;
    localparam int CMAX = 255;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_i        = 1'b1;
    logic          sensor_raw_i = 1'b0;
    logic          farm_green_i = 1'b0;
    logic          count_clr_i  = 1'b0;
    logic          sensor_o;
    logic [CW-1:0] veh_count_o;
    logic          veh_sat_o;

    farm_sensor_qualifier #(
        .DEBOUNCE_CYCLES(D),
        .GAP_CYCLES     (G),
        .CNT_W          (CW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .sensor_raw_i(sensor_raw_i),
        .farm_green_i(farm_green_i),
        .count_clr_i (count_clr_i),
        .sensor_o    (sensor_o),
        .veh_count_o (veh_count_o),
        .veh_sat_o   (veh_sat_o)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: raw is delayed two edges, the debounced level flips
    // when the last D delayed samples all disagree with it, and the request
    // is a pending/serving pair of flags with a count of idle green cycles.
    bit m_s1, m_s2, m_deb, m_arr, m_req, m_serv;
    int m_gap, m_cnt;
    bit win[$];

    task automatic model_step();
        bit deb_old;
        bit all_diff;
        deb_old = m_deb;
        if (rst_i) begin
            m_s1 = 0; m_s2 = 0; m_deb = 0; m_arr = 0; m_req = 0; m_serv = 0;
            m_gap = 0; m_cnt = 0;
            win.delete();
            return;
        end
        if (count_clr_i) m_cnt = 0;
        else if (m_arr && m_cnt < CMAX) m_cnt++;
        if (!m_req) begin
            m_req = deb_old;
        end else if (!m_serv) begin
            if (farm_green_i) begin m_serv = 1; m_gap = 0; end
        end else if (!farm_green_i) begin
            m_serv = 0; m_req = deb_old;
        end else if (deb_old) begin
            m_gap = 0;
        end else begin
            m_gap++;
            if (m_gap >= G) begin m_req = 0; m_serv = 0; end
        end
        win.push_back(m_s2);
        if (win.size() > D) void'(win.pop_front());
        if (win.size() == D) begin
            all_diff = 1;
            foreach (win[i]) if (win[i] == m_deb) all_diff = 0;
            if (all_diff) m_deb = ~m_deb;
        end
        m_arr = m_deb & ~deb_old;
        m_s2  = m_s1;
        m_s1  = sensor_raw_i;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic apply_reset();
        rst_i = 1'b1;
        repeat (2) tick();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        sensor_raw_i = 1'b1; farm_green_i = 1'b0; count_clr_i = 1'b0; rst_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if (sensor_o !== 1'b0 || veh_count_o !== 8'd0 || veh_sat_o !== 1'b0)
                $display("FAIL reset_hold cyc=%0d: got sensor=%0b count=%0d sat=%0b, expected 0/0/0", c, sensor_o, veh_count_o, veh_sat_o);
            else n_pass++;
        end
        rst_i = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            n_checks++;
            if (sensor_o !== (k >= 7))
                $display("FAIL reset_release_latency edge=%0d: got sensor=%0b, expected %0b", k, sensor_o, (k >= 7));
            else n_pass++;
            n_checks++;
            if (sensor_o !== m_req || veh_count_o !== CW'(m_cnt) || veh_sat_o !== (m_cnt == CMAX))
                $display("FAIL reset_model t=%0t: got sensor=%0b count=%0d sat=%0b, expected sensor=%0b count=%0d sat=%0b", $time, sensor_o, veh_count_o, veh_sat_o, m_req, m_cnt, (m_cnt == CMAX));
            else n_pass++;
        end
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        n_checks++;
        if (sensor_o !== 1'b0 || veh_count_o !== 8'd0)
            $display("FAIL reset_midop: got sensor=%0b count=%0d, expected sensor=0 count=0", sensor_o, veh_count_o);
        else n_pass++;
    endtask

    task automatic test_glitch();
        sensor_raw_i = 1'b0;
        apply_reset();
        for (int c = 0; c < 20; c++) begin
            sensor_raw_i = (c >= 2 && c < 5);
            tick();
            n_checks++;
            if (sensor_o !== 1'b0 || veh_count_o !== 8'd0)
                $display("FAIL glitch cyc=%0d: got sensor=%0b count=%0d, expected sensor=0 count=0", c, sensor_o, veh_count_o);
            else n_pass++;
            n_checks++;
            if (sensor_o !== m_req || veh_count_o !== CW'(m_cnt) || veh_sat_o !== (m_cnt == CMAX))
                $display("FAIL glitch_model t=%0t: got sensor=%0b count=%0d sat=%0b, expected sensor=%0b count=%0d sat=%0b", $time, sensor_o, veh_count_o, veh_sat_o, m_req, m_cnt, (m_cnt == CMAX));
            else n_pass++;
        end
    endtask

    task automatic test_latch();
        apply_reset();
        farm_green_i = 1'b0;
        for (int c = 0; c < 50; c++) begin
            sensor_raw_i = (c < 10);
            tick();
            n_checks++;
            if (sensor_o !== m_req || veh_count_o !== CW'(m_cnt) || veh_sat_o !== (m_cnt == CMAX))
                $display("FAIL latch_model t=%0t: got sensor=%0b count=%0d sat=%0b, expected sensor=%0b count=%0d sat=%0b", $time, sensor_o, veh_count_o, veh_sat_o, m_req, m_cnt, (m_cnt == CMAX));
            else n_pass++;
        end
        n_checks++;
        if (sensor_o !== 1'b1 || veh_count_o !== 8'd1)
            $display("FAIL latch_hold: got sensor=%0b count=%0d, expected sensor=1 count=1", sensor_o, veh_count_o);
        else n_pass++;
    endtask

    // Continues from the latched request left by test_latch.
    task automatic test_serve_gap();
        int drop;
        sensor_raw_i = 1'b0; farm_green_i = 1'b1;
        tick();
        drop = -1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (drop < 0 && sensor_o === 1'b0) drop = k;
        end
        n_checks++;
        if (drop !== 8) $display("FAIL gap_expiry: got drop at edge %0d, expected 8", drop);
        else n_pass++;
        farm_green_i = 1'b0;
        for (int c = 0; c < 18; c++) begin
            sensor_raw_i = (c < 8);
            tick();
            n_checks++;
            if (sensor_o !== m_req || veh_count_o !== CW'(m_cnt) || veh_sat_o !== (m_cnt == CMAX))
                $display("FAIL serve_model t=%0t: got sensor=%0b count=%0d sat=%0b, expected sensor=%0b count=%0d sat=%0b", $time, sensor_o, veh_count_o, veh_sat_o, m_req, m_cnt, (m_cnt == CMAX));
            else n_pass++;
        end
        n_checks++;
        if (sensor_o !== 1'b1) $display("FAIL gap_rearm_req: got sensor=%0b, expected 1", sensor_o);
        else n_pass++;
        farm_green_i = 1'b1; sensor_raw_i = 1'b1;
        tick();
        drop = -1;
        for (int k = 1; k <= 30; k++) begin
            sensor_raw_i = (k <= 5);
            tick();
            if (k == 8) begin
                n_checks++;
                if (sensor_o !== 1'b1) $display("FAIL gap_restart_hold: got sensor=%0b, expected 1", sensor_o);
                else n_pass++;
            end
            if (drop < 0 && sensor_o === 1'b0) drop = k;
            n_checks++;
            if (sensor_o !== m_req || veh_count_o !== CW'(m_cnt) || veh_sat_o !== (m_cnt == CMAX))
                $display("FAIL gap_restart_model t=%0t: got sensor=%0b count=%0d sat=%0b, expected sensor=%0b count=%0d sat=%0b", $time, sensor_o, veh_count_o, veh_sat_o, m_req, m_cnt, (m_cnt == CMAX));
            else n_pass++;
        end
        n_checks++;
        if (drop !== 19) $display("FAIL gap_restart_expiry: got drop at edge %0d, expected 19", drop);
        else n_pass++;
        n_checks++;
        if (veh_count_o !== 8'd3) $display("FAIL serve_count: got %0d, expected 3", veh_count_o);
        else n_pass++;
        farm_green_i = 1'b0; sensor_raw_i = 1'b0;
    endtask

    task automatic test_early_end();
        apply_reset();
        for (int c = 0; c < 40; c++) begin
            sensor_raw_i = (c < 16);
            farm_green_i = (c >= 8 && c < 11);
            tick();
            if (c >= 11) begin
                n_checks++;
                if (sensor_o !== 1'b1) $display("FAIL early_end_hold cyc=%0d: got sensor=%0b, expected 1", c, sensor_o);
                else n_pass++;
            end
            n_checks++;
            if (sensor_o !== m_req || veh_count_o !== CW'(m_cnt) || veh_sat_o !== (m_cnt == CMAX))
                $display("FAIL early_end_model t=%0t: got sensor=%0b count=%0d sat=%0b, expected sensor=%0b count=%0d sat=%0b", $time, sensor_o, veh_count_o, veh_sat_o, m_req, m_cnt, (m_cnt == CMAX));
            else n_pass++;
        end
    endtask

    task automatic test_idle_green();
        sensor_raw_i = 1'b0;
        apply_reset();
        farm_green_i = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            n_checks++;
            if (sensor_o !== 1'b0) $display("FAIL idle_green cyc=%0d: got sensor=%0b, expected 0", c, sensor_o);
            else n_pass++;
        end
        farm_green_i = 1'b0;
    endtask

    task automatic test_sat_clear();
        bit got_arr;
        apply_reset();
        for (int a = 0; a < 260; a++) begin
            int hi;
            int lo;
            hi = $urandom_range(4, 8);
            lo = $urandom_range(5, 8);
            for (int c = 0; c < hi + lo; c++) begin
                sensor_raw_i = (c < hi);
                farm_green_i = ($urandom_range(0, 3) == 0);
                tick();
                n_checks++;
                if (sensor_o !== m_req || veh_count_o !== CW'(m_cnt) || veh_sat_o !== (m_cnt == CMAX))
                    $display("FAIL sat_model t=%0t: got sensor=%0b count=%0d sat=%0b, expected sensor=%0b count=%0d sat=%0b", $time, sensor_o, veh_count_o, veh_sat_o, m_req, m_cnt, (m_cnt == CMAX));
                else n_pass++;
            end
        end
        sensor_raw_i = 1'b0; farm_green_i = 1'b0;
        repeat (10) tick();
        n_checks++;
        if (veh_count_o !== 8'd255 || veh_sat_o !== 1'b1)
            $display("FAIL saturation: got count=%0d sat=%0b, expected count=255 sat=1", veh_count_o, veh_sat_o);
        else n_pass++;
        sensor_raw_i = 1'b1;
        got_arr = 0;
        for (int w = 0; w < 20 && !got_arr; w++) begin
            tick();
            if (m_arr) got_arr = 1;
        end
        n_checks++;
        if (!got_arr) $display("FAIL clr_arrival_wait: got no arrival within 20 cycles, expected one");
        else n_pass++;
        count_clr_i = 1'b1;
        tick();
        count_clr_i = 1'b0;
        n_checks++;
        if (veh_count_o !== 8'd0 || veh_sat_o !== 1'b0)
            $display("FAIL clr_priority: got count=%0d sat=%0b, expected count=0 sat=0", veh_count_o, veh_sat_o);
        else n_pass++;
        for (int c = 0; c < 24; c++) begin
            sensor_raw_i = (c >= 12);
            tick();
        end
        n_checks++;
        if (veh_count_o !== 8'd1 || veh_count_o !== CW'(m_cnt))
            $display("FAIL count_after_clr: got %0d, expected 1 (model %0d)", veh_count_o, m_cnt);
        else n_pass++;
    endtask

    task automatic test_random();
        int raw_run = 0;
        int fg_run  = 0;
        apply_reset();
        for (int c = 0; c < 1500; c++) begin
            if (raw_run == 0) begin sensor_raw_i = ~sensor_raw_i; raw_run = $urandom_range(1, 12); end
            raw_run--;
            if (fg_run == 0) begin farm_green_i = ~farm_green_i; fg_run = $urandom_range(1, 30); end
            fg_run--;
            count_clr_i = ($urandom_range(0, 49) == 0);
            rst_i       = ($urandom_range(0, 299) == 0);
            tick();
            n_checks++;
            if (sensor_o !== m_req || veh_count_o !== CW'(m_cnt) || veh_sat_o !== (m_cnt == CMAX))
                $display("FAIL random_model t=%0t: got sensor=%0b count=%0d sat=%0b, expected sensor=%0b count=%0d sat=%0b", $time, sensor_o, veh_count_o, veh_sat_o, m_req, m_cnt, (m_cnt == CMAX));
            else n_pass++;
        end
        rst_i = 1'b0; count_clr_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_latch();
        test_serve_gap();
        test_early_end();
        test_idle_green();
        test_sat_clear();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
